// File: rtl/logic_pkg.sv
// Shared definitions for the logic_* stream blocks.
// Provides the implementation-target selector used as a parameter type by
// blocks that may map onto vendor-specific primitives.
package logic_pkg;

  typedef enum logic [1:0] {
    TARGET_GENERIC = 2'd0,
    TARGET_XILINX  = 2'd1,
    TARGET_INTEL   = 2'd2
  } target_e;

endpackage : logic_pkg

// File: rtl/logic_axi4_stream_if.sv
// AXI4-Stream bundle shared by the logic_* stream blocks.
// Parameters set the data byte count and sideband widths.
// Modports:
//   rx - sink side: payload/tvalid are inputs, tready is an output
//   tx - source side: payload/tvalid are outputs, tready is an input
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1
);

  logic                       tvalid;
  logic                       tready;
  logic [8*TDATA_BYTES-1:0]   tdata;
  logic [TDATA_BYTES-1:0]     tkeep;
  logic [TDATA_BYTES-1:0]     tstrb;
  logic                       tlast;
  logic [TID_WIDTH-1:0]       tid;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TUSER_WIDTH-1:0]     tuser;

  modport rx (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );

  modport tx (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

endinterface : logic_axi4_stream_if

// File: rtl/logic_axi4_stream_upsizer.sv
// AXI4-Stream width upsizer: packs RATIO narrow rx beats into one wide tx
// beat. Lane 0 (least-significant) holds the first beat of a word. A word
// closes when its last lane fills, on an rx tlast, or early when the
// incoming tid/tdest differs from the word being built.
// Ports:
//   aclk     - clock, all state changes on the rising edge
//   areset_n - asynchronous active-low reset
//   rx       - input stream, TDATA_BYTES bytes per beat
//   tx       - packed output stream, TDATA_BYTES*RATIO bytes per beat
// The packing register doubles as the tx output register, so tx payload is
// fully registered and held while tx is stalled.
module logic_axi4_stream_upsizer
  import logic_pkg::*;
#(
  parameter target_e TARGET      = TARGET_GENERIC,
  parameter int      TDATA_BYTES = 1,
  parameter int      RATIO       = 4,
  parameter int      TDEST_WIDTH = 1,
  parameter int      TUSER_WIDTH = 1,
  parameter int      TID_WIDTH   = 1,
  parameter int      USE_TLAST   = 1,
  parameter int      USE_TKEEP   = 1,
  parameter int      USE_TSTRB   = 1
) (
  input logic             aclk,
  input logic             areset_n,
  logic_axi4_stream_if.rx rx,
  logic_axi4_stream_if.tx tx
);

  localparam int LANE_BITS  = 8 * TDATA_BYTES;
  localparam int WORD_BYTES = TDATA_BYTES * RATIO;
  localparam int WORD_BITS  = 8 * WORD_BYTES;
  localparam int CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  // state
  logic [CNT_W-1:0]       cnt_r;
  logic                   out_valid_r;
  logic [WORD_BITS-1:0]   data_r;
  logic [WORD_BYTES-1:0]  keep_r;
  logic [WORD_BYTES-1:0]  strb_r;
  logic                   last_r;
  logic [TID_WIDTH-1:0]   tid_r;
  logic [TDEST_WIDTH-1:0] tdest_r;
  logic [TUSER_WIDTH-1:0] tuser_r;

  // next-state
  logic [CNT_W-1:0]       cnt_s;
  logic                   out_valid_s;
  logic [WORD_BITS-1:0]   data_s;
  logic [WORD_BYTES-1:0]  keep_s;
  logic [WORD_BYTES-1:0]  strb_s;
  logic                   last_s;
  logic [TID_WIDTH-1:0]   tid_s;
  logic [TDEST_WIDTH-1:0] tdest_s;
  logic [TUSER_WIDTH-1:0] tuser_s;

  // handshake helpers
  logic                   tx_fire_s;
  logic                   mismatch_s;
  logic                   rx_ready_s;
  logic                   rx_fire_s;
  logic                   beat_last_s;
  logic [TDATA_BYTES-1:0] lane_keep_s;
  logic [TDATA_BYTES-1:0] lane_strb_s;

  // A partial word whose stream identity no longer matches rx is flushed
  // first; the new beat waits one cycle and then opens a fresh word.
  assign tx_fire_s  = out_valid_r && tx.tready;
  assign mismatch_s = rx.tvalid && !out_valid_r && (cnt_r != {CNT_W{1'b0}}) &&
                      ((rx.tid != tid_r) || (rx.tdest != tdest_r));
  // areset_n term keeps tready low while reset is held
  assign rx_ready_s = areset_n && (!out_valid_r || tx.tready) && !mismatch_s;
  assign rx_fire_s  = rx.tvalid && rx_ready_s;

  assign beat_last_s = (USE_TLAST > 0) ? rx.tlast : 1'b0;
  assign lane_keep_s = (USE_TKEEP > 0) ? rx.tkeep : {TDATA_BYTES{1'b1}};
  assign lane_strb_s = (USE_TSTRB > 0) ? rx.tstrb : {TDATA_BYTES{1'b1}};

  // Next-state: tx drain, early flush on sideband change, lane fill and close
  always_comb begin
    cnt_s       = cnt_r;
    out_valid_s = out_valid_r;
    data_s      = data_r;
    keep_s      = keep_r;
    strb_s      = strb_r;
    last_s      = last_r;
    tid_s       = tid_r;
    tdest_s     = tdest_r;
    tuser_s     = tuser_r;

    if (tx_fire_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    if (mismatch_s) begin
      out_valid_s = 1'b1;
      cnt_s       = {CNT_W{1'b0}};
      last_s      = 1'b0;
    end else if (rx_fire_s) begin
      // lane 0 opens a word: clear stale lanes and latch stream identity
      if (cnt_r == {CNT_W{1'b0}}) begin
        data_s  = {WORD_BITS{1'b0}};
        keep_s  = {WORD_BYTES{1'b0}};
        strb_s  = {WORD_BYTES{1'b0}};
        last_s  = 1'b0;
        tid_s   = rx.tid;
        tdest_s = rx.tdest;
        tuser_s = rx.tuser;
      end else begin
        tid_s   = tid_r;
      end

      for (int l = 0; l < RATIO; l++) begin
        if (CNT_W'(l) == cnt_r) begin
          data_s[l*LANE_BITS +: LANE_BITS]     = rx.tdata;
          keep_s[l*TDATA_BYTES +: TDATA_BYTES] = lane_keep_s;
          strb_s[l*TDATA_BYTES +: TDATA_BYTES] = lane_strb_s;
        end else begin
          data_s[l*LANE_BITS +: LANE_BITS]     = data_s[l*LANE_BITS +: LANE_BITS];
        end
      end

      if ((cnt_r == LAST_LANE) || beat_last_s) begin
        out_valid_s = 1'b1;
        cnt_s       = {CNT_W{1'b0}};
        last_s      = beat_last_s;
      end else begin
        cnt_s       = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output word register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      data_r      <= {WORD_BITS{1'b0}};
      keep_r      <= {WORD_BYTES{1'b0}};
      strb_r      <= {WORD_BYTES{1'b0}};
      last_r      <= 1'b0;
      tid_r       <= {TID_WIDTH{1'b0}};
      tdest_r     <= {TDEST_WIDTH{1'b0}};
      tuser_r     <= {TUSER_WIDTH{1'b0}};
    end else begin
      cnt_r       <= cnt_s;
      out_valid_r <= out_valid_s;
      data_r      <= data_s;
      keep_r      <= keep_s;
      strb_r      <= strb_s;
      last_r      <= last_s;
      tid_r       <= tid_s;
      tdest_r     <= tdest_s;
      tuser_r     <= tuser_s;
    end
  end

  assign rx.tready = rx_ready_s;
  assign tx.tvalid = out_valid_r;
  assign tx.tdata  = data_r;
  assign tx.tkeep  = keep_r;
  assign tx.tstrb  = strb_r;
  assign tx.tlast  = last_r;
  assign tx.tid    = tid_r;
  assign tx.tdest  = tdest_r;
  assign tx.tuser  = tuser_r;

endmodule : logic_axi4_stream_upsizer

// File: doc/logic_axi4_stream_upsizer.md
LOGIC_AXI4_STREAM_UPSIZER -- requirements
Module: logic_axi4_stream_upsizer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named aclk and areset_n.
REQ-002 Parameter TARGET, default logic_pkg::TARGET_GENERIC: target device implementation.
REQ-003 Parameter TDATA_BYTES, default 1: rx tdata bytes per beat.
REQ-004 Parameter RATIO, default 4: rx beats packed per tx beat, >= 1.
REQ-005 Parameters TDEST_WIDTH, TUSER_WIDTH and TID_WIDTH, each default 1: sideband widths.
REQ-006 Parameters USE_TLAST, USE_TKEEP and USE_TSTRB, each default 1: optional signals enabled when > 0.
REQ-007 Port aclk  input  1: clock; all state changes on its rising edge.
REQ-008 Port areset_n  input  1: asynchronous active-low reset.
REQ-009 Port rx  AXI4-Stream rx modport  TDATA_BYTES bytes: input stream.
REQ-010 Port tx  AXI4-Stream tx modport  TDATA_BYTES*RATIO bytes: packed output stream, same sideband widths as rx.

Function
REQ-011 A beat transfers when tvalid && tready; the block SHALL NOT deassert tx.tvalid or change tx payload while tx.tvalid && !tx.tready.
REQ-012 State: lane counter cnt (0..RATIO-1), held flag out_valid that drives tx.tvalid, and output word register.
REQ-013 An accepted rx beat SHALL be written to lane cnt (byte offset cnt*TDATA_BYTES; lane 0 = least-significant, first beat); cnt then increments.
REQ-014 tid, tdest and tuser of the tx word SHALL come from the beat in lane 0.
REQ-015 The word SHALL close (out_valid<=1, cnt<=0) on the cycle the block accepts lane RATIO-1, or accepts a beat with tlast=1 when USE_TLAST>0.
REQ-016 On close, tx.tlast SHALL equal the tlast of the closing beat; unfilled lanes SHALL carry tdata=0, tkeep=0, tstrb=0.
REQ-017 With USE_TKEEP=0, all tx tkeep bits are 1 for filled lanes; tstrb follows the same rule.
REQ-018 If cnt>0, out_valid=0 and rx presents tid or tdest different from lane 0, the block SHALL close the partial word with tlast=0 and SHALL NOT accept that rx beat in that cycle.
REQ-019 rx.tready = (!out_valid || tx.tready) && !(sideband-mismatch condition of REQ-018).
REQ-020 Simultaneous tx transfer and rx acceptance SHALL start a new word at lane 0 in the same cycle: full throughput, one tx beat per RATIO rx beats with no bubble.
REQ-021 Latency: tx.tvalid SHALL rise on the clock edge after the closing rx beat is accepted (1 cycle).
REQ-022 RATIO=1 SHALL behave as a one-deep register slice with unchanged payload.

Reset
REQ-023 While areset_n=0: out_valid=0 (tx.tvalid=0), cnt=0, and output word tdata, tkeep, tstrb, tlast, tid, tdest and tuser all 0.
REQ-024 rx.tready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-025 Reset asserted mid-word SHALL discard the partial word; no tx beat for it may appear after release.

Structure
REQ-026 No new shared-package content is needed; the cnt width is a local constant, $clog2(RATIO) with a minimum of 1.
REQ-027 The FSM is implicit in cnt/out_valid and needs no enumerated type.
REQ-028 The block SHALL have no sub-module; the output register is implemented inline.
REQ-029 The block is intended to sit downstream of logic_axi4_stream_queue and connect through logic_axi4_stream_if.

Verification (TDATA_BYTES=1, RATIO=4)
REQ-030 rx 0x11,0x22,0x33,0x44 back-to-back, tx.tready=1 -> one tx beat 0x44332211, tkeep=0xF, one cycle after the 4th beat.
REQ-031 rx 0xAA,0xBB with tlast on 0xBB -> tx 0x0000BBAA, tkeep=0x3, tlast=1.
REQ-032 rx tid=1 0x01, then tid=2 0x02 -> tx 0x00000001, tkeep=0x1, tlast=0, tid=1; 0x02 is accepted one cycle later into lane 0.
REQ-033 12 rx beats continuous, tx.tready=1 -> 3 tx beats, rx.tready never low.
REQ-034 Word held with tx.tready=0 for 5 cycles -> tx payload stable, rx.tready=0, no data loss.
REQ-035 areset_n pulsed after 2 beats, then 4 new beats -> exactly one tx beat containing only the new beats.
